// File: rtl/as_op_responder.sv
// Registered Add/Sub/Inc/Switch responder. Each accepted request is evaluated once and
// queued in a small circular FIFO, so the consumer can apply backpressure.
module as_op_responder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add,
  input  logic             sub,
  input  logic             inc,
  input  logic             switch,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_flag,
  output logic [1:0]       rsp_op,
  output logic [7:0]       op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + 3;

  // Entry layout: {op[1:0], flag, c[WIDTH-1:0]}
  function automatic logic [EW-1:0] eval_op(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic do_add,
                                            input logic do_sub,
                                            input logic do_inc);
    logic [WIDTH:0] r;
    logic [1:0]     op;
    if (do_add) begin
      r  = {1'b0, x} + {1'b0, y};
      op = 2'd1;
    end else if (do_sub) begin
      r  = {1'b0, x} - {1'b0, y};
      op = 2'd2;
    end else if (do_inc) begin
      r  = {1'b0, x} + (WIDTH+1)'(1);
      op = 2'd3;
    end else begin
      r  = {1'b0, x};
      op = 2'd0;
    end
    return {op, r[WIDTH], r[WIDTH-1:0]};
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [EW-1:0] new_entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  assign x         = switch ? a : b;
  assign y         = switch ? b : a;
  assign new_entry = eval_op(x, y, add, sub, inc);

  assign req_ready = (count < CW'(DEPTH)) && !rst;
  assign rsp_valid = (count != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rd_next   = rd_ptr + PW'(1);

  assign rsp_c    = head[WIDTH-1:0];
  assign rsp_flag = head[WIDTH];
  assign rsp_op   = head[WIDTH+2:WIDTH+1];

  // Stage boundary: result storage, data only
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Stage boundary: control state and the registered head copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      op_count <= '0;
      head     <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        op_count <= op_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head only changes when a new entry becomes the head; an empty FIFO holds it
      if (pop) begin
        if (count > CW'(1))
          head <= mem[rd_next];
        else if (push)
          head <= new_entry;
      end else if (push && count == '0) begin
        head <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_as_op_responder.sv
// Bench for as_op_responder: table vectors, hand-built backpressure/reset sequences and
// random traffic, all checked against a queue-based reference model.
module tb_as_op_responder;

  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int MOD   = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         add = 1'b0;
  logic         sub = 1'b0;
  logic         inc = 1'b0;
  logic         switch = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_c;
  logic         rsp_flag;
  logic [1:0]   rsp_op;
  logic [7:0]   op_count;

  as_op_responder #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .add(add), .sub(sub), .inc(inc), .switch(switch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_flag(rsp_flag), .rsp_op(rsp_op),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int flag;
    int op;
  } ent_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic add;
    logic sub;
    logic inc;
    logic sw;
    int   c;
    int   flag;
    int   op;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  ent_t last_head = '{0, 0, 0};
  int   m_count = 0;
  vec_t vecs[11];

  function automatic ent_t model_op(int va, int vb, bit fa, bit fs, bit fi, bit sw);
    ent_t e;
    int x = sw ? va : vb;
    int y = sw ? vb : va;
    int s;
    if (fa) begin
      s = x + y;  e.c = s % MOD; e.flag = (s >= MOD); e.op = 1;
    end else if (fs) begin
      e.c = (x - y + MOD) % MOD; e.flag = (x < y); e.op = 2;
    end else if (fi) begin
      s = x + 1;  e.c = s % MOD; e.flag = (s >= MOD); e.op = 3;
    end else begin
      e.c = x; e.flag = 0; e.op = 0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rsp_valid", int'(rsp_valid), int'(q.size() != 0));
    check("req_ready", int'(req_ready), int'(q.size() < DEPTH));
    check("op_count", int'(op_count), m_count);
    check("rsp_c", int'(rsp_c), last_head.c);
    check("rsp_flag", int'(rsp_flag), last_head.flag);
    check("rsp_op", int'(rsp_op), last_head.op);
  endtask

  // One clock: model applies pop then push from the inputs seen at the edge
  task automatic step();
    bit do_push, do_pop;
    ent_t e;
    @(posedge clk);
    do_push = req_valid && (q.size() < DEPTH);
    do_pop  = rsp_ready && (q.size() > 0);
    e = model_op(int'(a), int'(b), add, sub, inc, switch);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(e);
      m_count = (m_count + 1) % 256;
    end
    if (q.size() > 0) last_head = q[0];
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_op_count", int'(op_count), 0);
    check("rst_rsp_c", int'(rsp_c), 0);
    q.delete();
    m_count   = 0;
    last_head = '{0, 0, 0};
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", int'(req_ready), 1);
  endtask

  task automatic rand_req();
    a = W'($urandom_range(0, MOD - 1));
    b = W'($urandom_range(0, MOD - 1));
    add = 1'($urandom_range(0, 2) == 0);
    sub = 1'($urandom_range(0, 2) == 0);
    inc = 1'($urandom_range(0, 2) == 0);
    switch = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    vecs[0]  = '{4'd9,  4'd2, 1, 0, 0, 1, 11, 0, 1};
    vecs[1]  = '{4'd9,  4'd2, 0, 1, 0, 1,  7, 0, 2};
    vecs[2]  = '{4'd9,  4'd2, 0, 0, 0, 1,  9, 0, 0};
    vecs[3]  = '{4'd9,  4'd2, 0, 0, 1, 1, 10, 0, 3};
    vecs[4]  = '{4'd9,  4'd2, 1, 0, 0, 0, 11, 0, 1};
    vecs[5]  = '{4'd9,  4'd2, 0, 1, 0, 0,  9, 1, 2};
    vecs[6]  = '{4'd9,  4'd2, 0, 0, 0, 0,  2, 0, 0};
    vecs[7]  = '{4'd9,  4'd2, 0, 0, 1, 0,  3, 0, 3};
    vecs[8]  = '{4'd15, 4'd1, 1, 0, 0, 1,  0, 1, 1};
    vecs[9]  = '{4'd15, 4'd1, 0, 0, 1, 1,  0, 1, 3};
    vecs[10] = '{4'd15, 4'd1, 1, 1, 1, 1,  0, 1, 1};

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_c", int'(rsp_c), 0);
    check("reset_rsp_flag", int'(rsp_flag), 0);
    check("reset_rsp_op", int'(rsp_op), 0);
    check("reset_op_count", int'(op_count), 0);
    rst = 1'b0;
    #1 check("ready_after_release", int'(req_ready), 1);

    // Table vectors, one per cycle with the consumer always ready
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a = vecs[i].a; b = vecs[i].b;
      add = vecs[i].add; sub = vecs[i].sub; inc = vecs[i].inc; switch = vecs[i].sw;
      step();
      check($sformatf("vec%0d_valid", i), int'(rsp_valid), 1);
      check($sformatf("vec%0d_c", i), int'(rsp_c), vecs[i].c);
      check($sformatf("vec%0d_flag", i), int'(rsp_flag), vecs[i].flag);
      check($sformatf("vec%0d_op", i), int'(rsp_op), vecs[i].op);
    end
    drain();

    // Backpressure: third request waits for one pop
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    a = 4'd3; b = 4'd4; add = 1; sub = 0; inc = 0; switch = 1;
    step();
    a = 4'd8; b = 4'd1; add = 0; sub = 1;
    step();
    check("bp_full_ready", int'(req_ready), 0);
    a = 4'd6; b = 4'd0; sub = 0; inc = 1;
    step();
    check("bp_held_count", int'(op_count), 2);
    check("bp_head_first", int'(rsp_c), 7);
    rsp_ready = 1'b1;
    step();
    check("bp_ready_after_pop", int'(req_ready), 1);
    check("bp_head_second", int'(rsp_c), 7);
    check("bp_head_second_op", int'(rsp_op), 2);
    rsp_ready = 1'b0;
    step();
    check("bp_op_count", int'(op_count), 3);
    drain();

    // Simultaneous push and pop with one entry resident
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    rand_req();
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_req();
      step();
      check("pp_ready", int'(req_ready), 1);
      check("pp_valid", int'(rsp_valid), 1);
    end
    drain();

    // Reset with two entries queued, then a fresh request
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    repeat (2) begin
      rand_req();
      step();
    end
    do_reset();
    a = 4'd5; b = 4'd6; add = 1; sub = 0; inc = 0; switch = 0;
    step();
    check("post_rst_valid", int'(rsp_valid), 1);
    check("post_rst_c", int'(rsp_c), 11);
    check("post_rst_op_count", int'(op_count), 1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      rand_req();
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/as_op_responder.md
# as_op_responder

Registered responder for the 4-bit Add/Sub/Inc/Switch operation interface. It accepts one operation request per handshake on the request side. It computes the result, carry or borrow flag, and an operation code, then holds the results in a small output FIFO until the consumer takes them. It sits between a stimulus or command initiator and any downstream checker or datapath, and replaces direct combinational use of the operation unit where backpressure is needed.

## Interface
- WIDTH, 4, operand and result width in bits
- DEPTH, 2, result FIFO depth in entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- add  input  1  add request
- sub  input  1  subtract request
- inc  input  1  increment request
- switch  input  1  1: primary operand x=a, y=b; 0: x=b, y=a
- rsp_valid  output  1  FIFO head holds a result
- rsp_ready  input  1  consumer takes the head this cycle
- rsp_c  output  WIDTH  result at FIFO head
- rsp_flag  output  1  carry (add/inc) or borrow (sub) at head; 0 for pass
- rsp_op  output  2  op code at head: 0 pass, 1 add, 2 sub, 3 inc
- op_count  output  8  count of accepted requests, wraps modulo 256

## Operation
- Accept: push = req_valid && req_ready. Pop = rsp_valid && rsp_ready.
- req_ready = (count < DEPTH) && !rst. It does not depend on rsp_ready, so there is no combinational ready path.
- Op priority: add > sub > inc > pass. Multiple flags set resolve to the highest-priority flag.
- Arithmetic is computed at WIDTH+1 bits and truncated to WIDTH:
  - add: c = x+y, flag = carry-out.
  - sub: c = x−y modulo 2^WIDTH, flag = (x<y).
  - inc: c = x+1, flag = carry-out. The y operand is ignored.
  - pass: c = x, flag = 0.
- Results are computed from the request inputs in the accept cycle and written into the FIFO with the write pointer. Inputs are not sampled in any other cycle.
- FIFO is circular:
  - Pointers wrap at DEPTH.
  - count ranges 0..DEPTH.
  - Outputs come from the head entry registers.
- op_count increments on each push and wraps 255→0.

## Timing
- Reset (asynchronous, immediate):
  - count, pointers and op_count are cleared to 0.
  - rsp_valid = 0, rsp_c = 0, rsp_flag = 0, rsp_op = 0, req_ready = 0.
  - req_ready rises once rst is deasserted, because count = 0.
- Latency: a request accepted at edge N into an empty FIFO gives rsp_valid = 1 with its result after edge N.
- Results are delivered strictly in accept order.
- Simultaneous push and pop with count < DEPTH:
  - Both take effect and count is unchanged.
  - When count = 1, the new entry becomes the head after the edge.
- Full (count = DEPTH):
  - req_ready = 0 and no push occurs.
  - A pop in that cycle frees one slot, and req_ready = 1 in the following cycle.
- Empty: rsp_valid = 0. rsp_ready is ignored and head outputs hold their last values.
- rsp_valid stays high and head outputs stay stable until popped.
- Reset mid-operation discards all stored results. No partial output follows reset release.

## Test plan
- Switch=1, a=4'b1001, b=4'b0010, rsp_ready=1, one request per cycle with add, then sub, then none, then inc:
  - rsp_c = 11, 7, 9, 10.
  - flags 0, 0, 0, 0.
  - rsp_op 1, 2, 0, 3.
  - Each result appears one cycle after its accept.
- Switch=0, same operands and op sequence:
  - rsp_c = 11, 9 (2−9), 2, 3.
  - flags 0, 1, 0, 0.
- Overflow: a=15, b=1, switch=1:
  - add → c = 0, flag 1.
  - inc → c = 0, flag 1.
  - add+sub+inc all set → treated as add.
- Backpressure: rsp_ready = 0, three back-to-back requests:
  - req_ready drops after 2 accepts.
  - Third is held until one pop, then accepted.
  - Order is preserved and op_count = 3.
- Simultaneous push/pop at count = 1 for 10 cycles: count stays 1, req_ready stays 1, outputs follow input order.
- Assert rst with 2 entries queued:
  - rsp_valid falls immediately and op_count = 0.
  - After release the first new request returns its result one cycle after accept.
